// File: rtl/pc_sequencer_pkg.sv
// pc_pkg: shared types and helpers for the program-counter sequencer.
//   redirect_e   - which redirect (if any) acts this cycle
//   sel_redirect - fixed-priority select RET > CALL > JUMP > BRANCH
//   ERR_OVF/UNF  - bit positions inside the sticky o_ERR vector
package pc_pkg;

  typedef enum logic [2:0] {
    NONE,
    BRANCH,
    JUMP,
    CALL,
    RET
  } redirect_e;

  localparam int ERR_OVF = 0;
  localparam int ERR_UNF = 1;

  // Only the winning request survives; losers lose their side effects too.
  function automatic redirect_e sel_redirect(input logic ret, input logic call,
                                             input logic jump, input logic branch);
    if (ret)         return RET;
    else if (call)   return CALL;
    else if (jump)   return JUMP;
    else if (branch) return BRANCH;
    else             return NONE;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: redirect inputs, fetch handshake and status outputs of the
// sequencer. Names are from the sequencer's point of view (i_ in, o_ out).
//   slave  - the sequencer itself
//   master - decode/branch-resolve plus the fetch port driving it
interface pc_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              i_PC_READY;
  logic              i_JUMP;
  logic              i_BRANCH;
  logic              i_CALL;
  logic              i_RET;
  logic [ADDR_W-1:0] i_TARGET;
  logic [ADDR_W-1:0] i_OFFSET;
  logic [ADDR_W-1:0] o_PC;
  logic              o_PC_VALID;
  logic              o_RAS_EMPTY;
  logic              o_RAS_FULL;
  logic [1:0]        o_ERR;

  modport slave (
    input  i_PC_READY, i_JUMP, i_BRANCH, i_CALL, i_RET, i_TARGET, i_OFFSET,
    output o_PC, o_PC_VALID, o_RAS_EMPTY, o_RAS_FULL, o_ERR
  );

  modport master (
    output i_PC_READY, i_JUMP, i_BRANCH, i_CALL, i_RET, i_TARGET, i_OFFSET,
    input  o_PC, o_PC_VALID, o_RAS_EMPTY, o_RAS_FULL, o_ERR
  );
endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// ras_stack: return-address stack as a circular buffer.
//   i_CLK, i_RST   clock, synchronous active-high reset
//   i_PUSH, i_DATA push i_DATA as the newest entry
//   i_POP          drop the newest entry (o_TOP is the value being popped)
//   o_TOP          newest entry
//   o_EMPTY/o_FULL count == 0 / count == RAS_DEPTH
//   o_OVF/o_UNF    single-cycle pulses: push while full / pop while empty
// A push while full overwrites the oldest slot, which is exactly the slot
// after the top pointer, so the count simply saturates.
module ras_stack #(
  parameter int ADDR_W    = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_PUSH,
  input  logic              i_POP,
  input  logic [ADDR_W-1:0] i_DATA,
  output logic [ADDR_W-1:0] o_TOP,
  output logic              o_EMPTY,
  output logic              o_FULL,
  output logic              o_OVF,
  output logic              o_UNF
);
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  r_top;
  logic [CNT_W-1:0]  r_cnt;
  logic [PTR_W-1:0]  w_top_inc;
  logic [PTR_W-1:0]  w_top_dec;

  // Explicit wrap so non-power-of-two depths work.
  assign w_top_inc = (r_top == PTR_MAX) ? '0 : r_top + PTR_W'(1);
  assign w_top_dec = (r_top == '0) ? PTR_MAX : r_top - PTR_W'(1);

  assign o_EMPTY = (r_cnt == '0);
  assign o_FULL  = (r_cnt == CNT_MAX);
  assign o_TOP   = r_mem[r_top];
  assign o_OVF   = i_PUSH && o_FULL;
  assign o_UNF   = i_POP && !i_PUSH && o_EMPTY;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_top <= '0;
      r_cnt <= '0;
    end else if (i_PUSH) begin
      r_top <= w_top_inc;
      if (!o_FULL) r_cnt <= r_cnt + CNT_W'(1);
    end else if (i_POP && !o_EMPTY) begin
      r_top <= w_top_dec;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Storage carries no reset; the count alone says what is meaningful.
  always_ff @(posedge i_CLK) begin
    if (!i_RST && i_PUSH) r_mem[w_top_inc] <= i_DATA;
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction fetch-address generator.
//   i_CLK, i_RST  clock, synchronous active-high reset
//   bus (slave)   redirects (JUMP/BRANCH/CALL/RET, TARGET, OFFSET), fetch
//                 handshake (o_PC/o_PC_VALID/i_PC_READY), RAS status and
//                 sticky error flags (bit ERR_OVF, bit ERR_UNF)
// Redirects win over the handshake: the pending address is dropped even if
// the fetch port never accepted it.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                 ADDR_W       = 8,
  parameter int                 RAS_DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0
) (
  input logic                i_CLK,
  input logic                i_RST,
  pc_sequencer_if.slave      bus
);
  logic [ADDR_W-1:0] r_pc;
  logic              r_vld;
  logic [1:0]        r_err;

  redirect_e         w_sel;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_ras_top;
  logic              w_ras_empty;
  logic              w_ras_full;
  logic              w_ovf;
  logic              w_unf;

  assign w_sel    = sel_redirect(bus.i_RET, bus.i_CALL, bus.i_JUMP, bus.i_BRANCH);
  assign w_pc_inc = r_pc + ADDR_W'(1);
  assign w_push   = (w_sel == CALL) && !i_RST;
  assign w_pop    = (w_sel == RET) && !i_RST;

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_CLK   (i_CLK),
    .i_RST   (i_RST),
    .i_PUSH  (w_push),
    .i_POP   (w_pop),
    .i_DATA  (w_pc_inc),
    .o_TOP   (w_ras_top),
    .o_EMPTY (w_ras_empty),
    .o_FULL  (w_ras_full),
    .o_OVF   (w_ovf),
    .o_UNF   (w_unf)
  );

  always_comb begin
    w_pc_nxt = r_pc;
    unique case (w_sel)
      RET:         w_pc_nxt = w_ras_empty ? RESET_VECTOR : w_ras_top;
      CALL, JUMP:  w_pc_nxt = bus.i_TARGET;
      BRANCH:      w_pc_nxt = r_pc + bus.i_OFFSET;
      default:     if (r_vld && bus.i_PC_READY) w_pc_nxt = w_pc_inc;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_pc  <= RESET_VECTOR;
      r_vld <= 1'b0;
      r_err <= 2'b00;
    end else begin
      r_pc           <= w_pc_nxt;
      r_vld          <= 1'b1;
      r_err[ERR_OVF] <= r_err[ERR_OVF] | w_ovf;
      r_err[ERR_UNF] <= r_err[ERR_UNF] | w_unf;
    end
  end

  assign bus.o_PC        = r_pc;
  assign bus.o_PC_VALID  = r_vld;
  assign bus.o_RAS_EMPTY = w_ras_empty;
  assign bus.o_RAS_FULL  = w_ras_full;
  assign bus.o_ERR       = r_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (ADDR_W=8, RAS_DEPTH=4, RESET_VECTOR=FE).
// Stimulus drives one cycle per vector on the falling edge and queues the
// hand-computed outputs expected after the next rising edge; the monitor
// pops and compares them just after that edge.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(8)) bus ();

  pc_sequencer #(
    .ADDR_W       (8),
    .RAS_DEPTH    (4),
    .RESET_VECTOR (8'hFE)
  ) dut (
    .i_CLK (clk),
    .i_RST (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] pc;
    logic       vld;
    logic       emp;
    logic       full;
    logic [1:0] err;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   vec    = 0;

  function automatic exp_t E(input logic [7:0] pc, input logic vld, input logic emp,
                             input logic full, input logic [1:0] err);
    exp_t e;
    e.pc = pc; e.vld = vld; e.emp = emp; e.full = full; e.err = err;
    return e;
  endfunction

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  // Monitor: whenever a queued expectation matches the edge just taken.
  initial begin : monitor
    exp_t e;
    int   idx = 0;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        idx++;
        chk("pc",    idx, int'(bus.o_PC),        int'(e.pc));
        chk("valid", idx, int'(bus.o_PC_VALID),  int'(e.vld));
        chk("empty", idx, int'(bus.o_RAS_EMPTY), int'(e.emp));
        chk("full",  idx, int'(bus.o_RAS_FULL),  int'(e.full));
        chk("err",   idx, int'(bus.o_ERR),       int'(e.err));
      end
    end
  end

  // One vector: rst, ready, jump, branch, call, ret, target, offset, expected.
  task automatic cyc(input logic r, input logic rdy, input logic j, input logic b,
                     input logic c, input logic rt, input logic [7:0] tgt,
                     input logic [7:0] off, input exp_t e);
    @(negedge clk);
    rst            = r;
    bus.i_PC_READY = rdy;
    bus.i_JUMP     = j;
    bus.i_BRANCH   = b;
    bus.i_CALL     = c;
    bus.i_RET      = rt;
    bus.i_TARGET   = tgt;
    bus.i_OFFSET   = off;
    sb.push_back(e);
    vec++;
    @(posedge clk);
  endtask

  initial begin : stim
    rst = 1'b1;
    bus.i_PC_READY = 1'b0; bus.i_JUMP = 1'b0; bus.i_BRANCH = 1'b0;
    bus.i_CALL = 1'b0; bus.i_RET = 1'b0; bus.i_TARGET = '0; bus.i_OFFSET = '0;

    // reset (redirect ignored), release, increment with wrap
    cyc(1,1,1,0,0,0,8'h33,8'h00, E(8'hFE,0,1,0,2'b00));
    cyc(1,1,0,0,0,0,8'h00,8'h00, E(8'hFE,0,1,0,2'b00));
    cyc(0,1,0,0,0,0,8'h00,8'h00, E(8'hFE,1,1,0,2'b00));
    cyc(0,1,0,0,0,0,8'h00,8'h00, E(8'hFF,1,1,0,2'b00));
    cyc(0,1,0,0,0,0,8'h00,8'h00, E(8'h00,1,1,0,2'b00));
    cyc(0,1,0,0,0,0,8'h00,8'h00, E(8'h01,1,1,0,2'b00));
    for (int i = 2; i <= 5; i++)
      cyc(0,1,0,0,0,0,8'h00,8'h00, E(8'(i),1,1,0,2'b00));
    // backpressure at 05, then jump during the stall
    for (int i = 0; i < 3; i++)
      cyc(0,0,0,0,0,0,8'h00,8'h00, E(8'h05,1,1,0,2'b00));
    cyc(0,0,1,0,0,0,8'h40,8'h00, E(8'h40,1,1,0,2'b00));
    cyc(0,0,0,0,0,0,8'h00,8'h00, E(8'h40,1,1,0,2'b00));
    cyc(0,1,0,0,0,0,8'h00,8'h00, E(8'h41,1,1,0,2'b00));
    // branches, both directions with wrap
    cyc(0,1,1,0,0,0,8'h10,8'h00, E(8'h10,1,1,0,2'b00));
    cyc(0,1,0,1,0,0,8'h00,8'hF8, E(8'h08,1,1,0,2'b00));
    cyc(0,1,1,0,0,0,8'hFC,8'h00, E(8'hFC,1,1,0,2'b00));
    cyc(0,1,0,1,0,0,8'h00,8'h08, E(8'h04,1,1,0,2'b00));
    // single call / return
    cyc(0,1,1,0,0,0,8'h20,8'h00, E(8'h20,1,1,0,2'b00));
    cyc(0,1,0,0,1,0,8'h80,8'h00, E(8'h80,1,0,0,2'b00));
    cyc(0,0,0,0,0,0,8'h00,8'h00, E(8'h80,1,0,0,2'b00));
    cyc(0,1,0,0,0,1,8'h00,8'h00, E(8'h21,1,1,0,2'b00));
    // nested calls: pushes 22, A1, B1, C1, then D1 overwrites 22
    cyc(0,1,0,0,1,0,8'hA0,8'h00, E(8'hA0,1,0,0,2'b00));
    cyc(0,1,0,0,1,0,8'hB0,8'h00, E(8'hB0,1,0,0,2'b00));
    cyc(0,1,0,0,1,0,8'hC0,8'h00, E(8'hC0,1,0,0,2'b00));
    cyc(0,1,0,0,1,0,8'hD0,8'h00, E(8'hD0,1,0,1,2'b00));
    cyc(0,1,0,0,1,0,8'hE0,8'h00, E(8'hE0,1,0,1,2'b01));
    cyc(0,1,0,0,0,1,8'h00,8'h00, E(8'hD1,1,0,0,2'b01));
    cyc(0,1,0,0,0,1,8'h00,8'h00, E(8'hC1,1,0,0,2'b01));
    cyc(0,1,0,0,0,1,8'h00,8'h00, E(8'hB1,1,0,0,2'b01));
    cyc(0,1,0,0,0,1,8'h00,8'h00, E(8'hA1,1,1,0,2'b01));
    // underflow, then RET+CALL+JUMP with empty stack: nothing pushed
    cyc(0,1,0,0,0,1,8'h00,8'h00, E(8'hFE,1,1,0,2'b11));
    cyc(0,1,1,0,1,1,8'h55,8'h00, E(8'hFE,1,1,0,2'b11));
    cyc(0,1,1,0,0,0,8'h30,8'h00, E(8'h30,1,1,0,2'b11));
    cyc(0,1,0,0,1,0,8'h60,8'h00, E(8'h60,1,0,0,2'b11));
    cyc(0,1,1,0,1,1,8'h70,8'h00, E(8'h31,1,1,0,2'b11));
    cyc(0,1,0,0,0,1,8'h00,8'h00, E(8'hFE,1,1,0,2'b11));
    // CALL beats JUMP/BRANCH, JUMP beats BRANCH
    cyc(0,1,1,1,1,0,8'h44,8'h05, E(8'h44,1,0,0,2'b11));
    cyc(0,1,1,1,0,0,8'h12,8'h03, E(8'h12,1,0,0,2'b11));
    // build count 3, then mid-operation reset with a jump
    cyc(0,1,0,0,1,0,8'h50,8'h00, E(8'h50,1,0,0,2'b11));
    cyc(0,1,0,0,1,0,8'h60,8'h00, E(8'h60,1,0,0,2'b11));
    cyc(1,1,1,0,0,0,8'h77,8'h00, E(8'hFE,0,1,0,2'b00));
    cyc(0,1,0,0,0,0,8'h00,8'h00, E(8'hFE,1,1,0,2'b00));
    cyc(0,1,0,0,0,0,8'h00,8'h00, E(8'hFF,1,1,0,2'b00));
    cyc(0,1,0,0,0,1,8'h00,8'h00, E(8'hFE,1,1,0,2'b10));

    @(negedge clk);
    @(negedge clk);
    chk("drain", vec, sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer, the next generation of the CPU's fetch-address counter. It generates the instruction fetch address `o_PC` with a valid/ready handshake toward instruction memory. It supports absolute jumps, PC-relative branches, and call/return through an internal return-address stack (RAS). It sits between the decode/branch-resolve stage, which issues redirects, and the instruction ROM address port.

## Interface
- `ADDR_W`, 8, width of the PC and all addresses.
- `RAS_DEPTH`, 4, number of return-address stack entries; must be at least 2.
- `RESET_VECTOR`, 0, PC value loaded on reset; `ADDR_W` bits wide.

- `i_CLK`  in  1  clock. All state changes on the posedge.
- `i_RST`  in  1  synchronous, active-high reset.
- `i_PC_READY`  in  1  fetch port accepts `o_PC` this cycle.
- `i_JUMP`  in  1  redirect to `i_TARGET`.
- `i_BRANCH`  in  1  redirect to `o_PC + i_OFFSET`.
- `i_CALL`  in  1  push `o_PC + 1`, then redirect to `i_TARGET`.
- `i_RET`  in  1  pop the RAS and redirect to the popped address.
- `i_TARGET`  in  `ADDR_W`  absolute target for JUMP and CALL.
- `i_OFFSET`  in  `ADDR_W`  two's-complement offset for BRANCH.
- `o_PC`  out  `ADDR_W`  current fetch address.
- `o_PC_VALID`  out  1  `o_PC` is a valid fetch request.
- `o_RAS_EMPTY`  out  1  RAS holds 0 entries.
- `o_RAS_FULL`  out  1  RAS holds `RAS_DEPTH` entries.
- `o_ERR`  out  2  sticky error flags: bit0 = RAS overflow, bit1 = RAS underflow.

## Operation
- **Reset values** (on any cycle with `i_RST`=1, including mid-operation):
  - `o_PC`=`RESET_VECTOR`, `o_PC_VALID`=0.
  - RAS count=0, so `o_RAS_EMPTY`=1 and `o_RAS_FULL`=0.
  - `o_ERR`=2'b00.
- **Valid:** `o_PC_VALID` rises the first cycle after reset deasserts, then stays 1 until the next reset.
- **Redirect priority** when several are asserted: RET > CALL > JUMP > BRANCH. Lower-priority requests in the same cycle are dropped entirely, including their stack side effects.
- **Redirects are taken regardless of `i_PC_READY`.** A redirect replaces the pending address; the un-accepted old address is discarded.
- **No redirect:**
  - `o_PC_VALID`=1 and `i_PC_READY`=1: `o_PC <= o_PC + 1`.
  - Otherwise `o_PC` holds.
- **Redirects during reset** are ignored.
- **Arithmetic:** all address arithmetic is modulo 2^`ADDR_W`.
  - Increment wraps from all-ones to 0.
  - BRANCH sign-extends nothing; it is a plain `ADDR_W`-bit add, so the offset wraps naturally.
- **CALL:**
  - Pushes `o_PC + 1` (wrapped).
  - If the RAS is full, the oldest entry is overwritten (circular buffer), the count stays `RAS_DEPTH`, and `o_ERR[0]` is set.
- **RET:**
  - Pops the newest entry into `o_PC`.
  - If the RAS is empty, `o_PC <= RESET_VECTOR`, the count stays 0, and `o_ERR[1]` is set.
- **Error flags:** `o_ERR` bits are sticky and cleared only by reset.

## Timing
- **Latency:** all outputs are registered; there is no combinational input-to-output path.
- **Redirect latency:** a redirect sampled at edge N puts the new `o_PC` on the output after edge N, so it is fetched in cycle N+1.
- **RAS flags:** `o_RAS_EMPTY` and `o_RAS_FULL` reflect the count after the same edge as the push/pop.
- **Back-to-back operations:**
  - A CALL followed immediately by a RET returns to the caller's `o_PC + 1`.
  - RAS state updates in one cycle, so a RET in cycle N+1 sees the push from cycle N.
- **Handshake:** under `i_PC_READY`=0, `o_PC` and `o_PC_VALID` are stable until acceptance or redirect.

## Structure
- **Package `pc_pkg`:**
  - `redirect_e` enum: NONE, BRANCH, JUMP, CALL, RET.
  - Priority-select function.
  - Error-bit index constants `ERR_OVF`=0, `ERR_UNF`=1.
- **Sub-module `ras_stack`** (parameters `ADDR_W`, `RAS_DEPTH`):
  - Circular buffer with top pointer and saturating count.
  - Push/pop inputs, top-data output, empty/full, overflow/underflow pulses.
- **`pc_sequencer`:** owns the PC register, valid flag, redirect mux and sticky errors.

## Test plan
- **Reset/increment:** `ADDR_W`=8, `RESET_VECTOR`=8'hFE; release reset with ready=1 → `o_PC_VALID` rises, PC sequence FE, FF, 00, 01 (wrap).
- **Backpressure:** ready=0 for 3 cycles at PC=05 → PC stays 05; JUMP to 40 during the stall → PC=40 next cycle, and 05 is never accepted.
- **Branch:** PC=10, BRANCH with `i_OFFSET`=8'hF8 (−8) → PC=08; at PC=FC, offset=8 → PC=04.
- **Call/return:** CALL to 80 at PC=20 → PC=80, RAS holds 21; RET → PC=21, empty=1; nested calls to depth 4 → full=1; fifth CALL → `o_ERR`=01, and 4 RETs return the 2nd–5th return addresses (newest first).
- **Underflow/priority:** RET with an empty RAS → PC=`RESET_VECTOR`, `o_ERR`=10; RET+CALL+JUMP in the same cycle → only RET acts, no push.
- **Mid-operation reset:** `i_RST` with RAS count 3 and `o_ERR`=11 → all outputs return to their reset values at the next edge, and a redirect in that cycle is ignored.
